// File: rtl/read_packet_from_mem_if.sv
// Bus bundle for read_packet_from_mem: length-FIFO pop side, SRAM read port
// and the outgoing byte stream towards the TX MAC.
interface read_packet_from_mem_if #(
  parameter int pLEN_WIDTH  = 16,
  parameter int pDATA_WIDTH = 8,
  parameter int pADDR_W     = 12
);
  // Handshakes: the FIFO is first-word-fall-through, ilen_data is valid while
  // !ilen_empty and one olen_rd pulse consumes the head. The SRAM returns
  // iram_data one cycle after oram_addr. The byte stream has no back-pressure:
  // itx_ready only gates the start of a packet, after which odv is high for a
  // contiguous run of bytes, osof/olast qualified by odv.
  logic                   ilen_empty;
  logic [pLEN_WIDTH-1:0]  ilen_data;
  logic                   olen_rd;
  logic [pADDR_W-1:0]     oram_addr;
  logic [pDATA_WIDTH-1:0] iram_data;
  logic                   itx_ready;
  logic                   odv;
  logic [pDATA_WIDTH-1:0] otx_d;
  logic                   osof;
  logic                   olast;

  modport master (
    input  ilen_empty, ilen_data, iram_data, itx_ready,
    output olen_rd, oram_addr, odv, otx_d, osof, olast
  );

  modport slave (
    output ilen_empty, ilen_data, iram_data, itx_ready,
    input  olen_rd, oram_addr, odv, otx_d, osof, olast
  );
endinterface

// File: rtl/read_packet_from_mem.sv
// Packet buffer drain: pops lengths, streams the matching SRAM bytes, then holds
// an inter-frame gap. Define STRIP_FCS_EN to drop the trailing 4 FCS bytes.
module read_packet_from_mem #(
  parameter int pLEN_WIDTH  = 16,
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH_RAM  = 3072,
  parameter int pMAX_LEN    = 1536,
  parameter int pIFG        = 12,
  parameter int pADDR_W     = $clog2(pDEPTH_RAM)
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  read_packet_from_mem_if.master bus,
  output logic                   oerr_len,
  output logic [pADDR_W-1:0]     orel_addr,
  output logic                   obusy,
  output logic [2:0]             ostate
);

`ifdef STRIP_FCS_EN
  localparam int pFCS = 4;
`else
  localparam int pFCS = 0;
`endif

  localparam logic [pLEN_WIDTH-1:0] MAX_L     = pLEN_WIDTH'(pMAX_LEN);
  localparam logic [pLEN_WIDTH-1:0] FCS_L     = pLEN_WIDTH'(pFCS);
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE   = pLEN_WIDTH'(1);
  localparam logic [pADDR_W-1:0]    ADDR_LAST = pADDR_W'(pDEPTH_RAM - 1);
  localparam logic [31:0]           DEPTH_U   = 32'(pDEPTH_RAM);
  localparam logic [15:0]           IFG_END   = 16'(pIFG - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_SKIP  = 3'd3,
    S_IFG   = 3'd4
  } state_t;

  state_t                 state, state_nx;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [pLEN_WIDTH-1:0]  cnt_q;
  logic [pLEN_WIDTH-1:0]  last_idx;
  logic [pADDR_W-1:0]     rd_ptr;
  logic [pADDR_W-1:0]     addr_q;
  logic [pADDR_W-1:0]     ptr_adv;
  logic [31:0]            ptr_sum;
  logic [15:0]            ifg_cnt;
  logic                   accept;
  logic                   len_bad;
  logic                   olen_rd_q;
  // Read pipeline: stage 1 tracks the SRAM output, stage 2 the capture
  // register, then the output register.
  logic                   rv1, sof1, last1;
  logic                   rv2, sof2, last2;
  logic [pDATA_WIDTH-1:0] ram_q;
  logic                   odv_q, osof_q, olast_q;
  logic [pDATA_WIDTH-1:0] otx_q;
  logic                   last_out;

  assign accept   = (state == S_IDLE) && !bus.ilen_empty && bus.itx_ready;
  assign len_bad  = (bus.ilen_data <= FCS_L) || (bus.ilen_data > MAX_L);
  assign last_idx = len_q - FCS_L - LEN_ONE;
  assign last_out = rv2 && last2;
  // The pointer always advances by the full stored length, FCS included.
  assign ptr_sum  = 32'(rd_ptr) + 32'(len_q);
  assign ptr_adv  = pADDR_W'(ptr_sum % DEPTH_U);

  always_ff @(posedge iclk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = len_bad ? S_SKIP : S_READ;
      S_READ:  if (cnt_q == last_idx) state_nx = S_DRAIN;
      S_DRAIN: if (last_out) state_nx = S_IFG;
      S_SKIP:  state_nx = S_IDLE;
      S_IFG:   if (ifg_cnt >= IFG_END) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (i_rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      rd_ptr    <= '0;
      addr_q    <= '0;
      orel_addr <= '0;
      ifg_cnt   <= '0;
      olen_rd_q <= 1'b0;
      rv1       <= 1'b0;
      sof1      <= 1'b0;
      last1     <= 1'b0;
      rv2       <= 1'b0;
      sof2      <= 1'b0;
      last2     <= 1'b0;
      ram_q     <= '0;
      odv_q     <= 1'b0;
      osof_q    <= 1'b0;
      olast_q   <= 1'b0;
      otx_q     <= '0;
    end else begin
      olen_rd_q <= accept;
      rv1       <= (state == S_READ);
      sof1      <= (state == S_READ) && (cnt_q == '0);
      last1     <= (state == S_READ) && (cnt_q == last_idx);
      rv2       <= rv1;
      sof2      <= sof1;
      last2     <= last1;
      ram_q     <= bus.iram_data;
      odv_q     <= rv2;
      osof_q    <= rv2 && sof2;
      olast_q   <= rv2 && last2;
      otx_q     <= ram_q;
      case (state)
        S_IDLE: begin
          if (accept) begin
            len_q  <= bus.ilen_data;
            addr_q <= rd_ptr;
            cnt_q  <= '0;
          end
        end
        S_READ: begin
          if (cnt_q != last_idx) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + pADDR_W'(1);
            cnt_q  <= cnt_q + LEN_ONE;
          end
        end
        S_DRAIN: begin
          // IFG occupies the olast cycle too, so it counts from 1.
          if (last_out) begin
            rd_ptr    <= ptr_adv;
            orel_addr <= ptr_adv;
            ifg_cnt   <= 16'd1;
          end
        end
        S_SKIP: begin
          rd_ptr    <= ptr_adv;
          orel_addr <= ptr_adv;
        end
        S_IFG:   ifg_cnt <= ifg_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.olen_rd   = olen_rd_q;
  assign bus.oram_addr = addr_q;
  assign bus.odv       = odv_q;
  assign bus.otx_d     = otx_q;
  assign bus.osof      = osof_q;
  assign bus.olast     = olast_q;
  assign oerr_len      = (state == S_SKIP);
  assign obusy         = (state != S_IDLE);
  assign ostate        = state;

endmodule

// File: tb/tb_read_packet_from_mem.sv
// Directed bench for read_packet_from_mem: FIFO and SRAM models, byte
// scoreboard fed at enqueue time, monitor popping on every odv.
module tb_read_packet_from_mem;
  localparam int LW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;
  localparam int IFG   = 12;
`ifdef STRIP_FCS_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic iclk  = 1'b0;
  logic i_rst = 1'b1;
  initial forever #5 iclk = ~iclk;

  logic          oerr_len;
  logic          obusy;
  logic [AW-1:0] orel_addr;
  logic [2:0]    ostate;
  int            cyc = 0;

  read_packet_from_mem_if #(.pLEN_WIDTH(LW), .pDATA_WIDTH(DW), .pADDR_W(AW)) bus ();

  read_packet_from_mem #(
    .pLEN_WIDTH(LW), .pDATA_WIDTH(DW), .pDEPTH_RAM(DEPTH), .pMAX_LEN(1536), .pIFG(IFG)
  ) dut (
    .iclk(iclk), .i_rst(i_rst), .bus(bus),
    .oerr_len(oerr_len), .orel_addr(orel_addr), .obusy(obusy), .ostate(ostate)
  );

  always @(posedge iclk) cyc <= cyc + 1;

  // ---------------- SRAM and FIFO models ----------------
  logic [DW-1:0] mem [DEPTH];
  always @(posedge iclk) bus.iram_data <= mem[bus.oram_addr];

  logic [LW-1:0] fifo_mem [16];
  int f_wr = 0;
  int f_rd = 0;
  assign bus.ilen_empty = (f_wr == f_rd);
  assign bus.ilen_data  = fifo_mem[f_rd % 16];
  always @(posedge iclk) if (bus.olen_rd) f_rd <= f_rd + 1;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW+1:0] exp_q[$];
  int rel_q[$];
  int exp_ptr = 0;
  int olen_cnt = 0;
  int err_cnt = 0;
  int rd_cyc = 0;
  int sof_log[$];
  int last_log[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_len(int len);
    logic [DW+1:0] e;
    fifo_mem[f_wr % 16] = LW'(len);
    f_wr++;
    if (len > FCS && len <= 1536) begin
      for (int i = 0; i < len - FCS; i++) begin
        e = {1'(i == 0), 1'(i == len - FCS - 1), mem[(exp_ptr + i) % DEPTH]};
        exp_q.push_back(e);
      end
      rel_q.push_back((exp_ptr + len) % DEPTH);
    end
    exp_ptr = (exp_ptr + len) % DEPTH;
  endtask

  // ---------------- monitor ----------------
  always @(negedge iclk) begin
    logic [DW+1:0] e;
    if (!i_rst) begin
      if (bus.olen_rd) begin
        olen_cnt++;
        rd_cyc = cyc;
      end
      if (oerr_len) err_cnt++;
      if (bus.odv) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("byte_sof_last_data", int'({bus.osof, bus.olast, bus.otx_d}), int'(e));
        end
        if (bus.osof) sof_log.push_back(cyc);
        if (bus.olast) begin
          last_log.push_back(cyc);
          if (rel_q.size() == 0) check("unexpected_olast", 1, 0);
          else check("rel_addr_at_olast", int'(orel_addr), rel_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge iclk);
    #2;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    logic ok;
    do begin
      tick();
      n++;
      ok = bus.ilen_empty && !obusy && (exp_q.size() == 0);
    end while (!ok && n < budget);
    check("drain_within_budget", int'(ok), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int err0;
  int n;
  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
    bus.itx_ready = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_odv", int'(bus.odv), 0);
    check("rst_olen_rd", int'(bus.olen_rd), 0);
    check("rst_orel_addr", int'(orel_addr), 0);
    check("rst_obusy", int'(obusy), 0);
    check("rst_oerr_len", int'(oerr_len), 0);
    check("rst_oram_addr", int'(bus.oram_addr), 0);
    i_rst = 1'b0;

    // itx_ready low holds the entry, then a 64-byte packet
    push_len(64);
    repeat (5) tick();
    check("no_pop_while_not_ready", olen_cnt, 0);
    check("idle_while_not_ready", int'(obusy), 0);
    bus.itx_ready = 1'b1;
    tick();
    check("olen_rd_after_accept", int'(bus.olen_rd), 1);
    check("obusy_after_accept", int'(obusy), 1);
    wait_done(400);
    check("single_pop", olen_cnt, 1);
    check("first_byte_latency", (sof_log.size() > 0) ? sof_log[0] - rd_cyc : -1, 3);
    check("rel_after_64", int'(orel_addr), 64);

    // back-to-back: 60 then a single output byte
    sof_log.delete();
    last_log.delete();
    push_len(60);
    push_len(1 + FCS);
    wait_done(400);
    check("b2b_gap", (sof_log.size() >= 2 && last_log.size() >= 1) ?
          sof_log[1] - last_log[0] : -1, IFG + 3);
    check("b2b_rel", int'(orel_addr), 125 + FCS);

    // advance pointer to 3070 with a discarded entry, then wrap
    err0 = err_cnt;
    push_len(3070 - exp_ptr);
    push_len(4 + FCS);
    wait_done(400);
    check("wrap_rel", int'(orel_addr), 2 + FCS);
    check("wrap_err_count", err_cnt - err0, 1);

    // discarded 0 and 2000, then 10 bytes from the advanced pointer
    err0 = err_cnt;
    sof_log.delete();
    push_len(0);
    push_len(2000);
    push_len(10);
    wait_done(400);
    check("skip_err_count", err_cnt - err0, 2);
    check("skip_one_packet", sof_log.size(), 1);
    check("skip_rel", int'(orel_addr), 2012 + FCS);

    // reset on the 5th byte of a 64-byte packet
    push_len(64);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.odv && bus.osof) && n < 50);
    check("rst_test_sof_seen", int'(bus.odv && bus.osof), 1);
    repeat (4) tick();
    i_rst = 1'b1;
    tick();
    check("midrst_odv", int'(bus.odv), 0);
    check("midrst_orel", int'(orel_addr), 0);
    check("midrst_obusy", int'(obusy), 0);
    exp_q.delete();
    rel_q.delete();
    exp_ptr = 0;
    i_rst = 1'b0;
    repeat (8) tick();
    check("post_rst_quiet", int'(bus.odv), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
